// File: rtl/os_decoder_multilane.sv
// Per-lane ordered-set collector: aligns each lane on its start symbol, gathers OS_LEN symbols,
// drops SKP sets and emits one lane-major block when all active lanes finish in the same beat.
module os_decoder_multilane #(
  parameter int MAX_LANES    = 16,
  parameter int SYMS_PER_CLK = 4,
  parameter int OS_LEN       = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [2:0]                          gen,
  input  logic [4:0]                          numberOfDetectedLanes,
  input  logic [MAX_LANES*SYMS_PER_CLK*8-1:0] data,
  input  logic                                validFromLMC,
  input  logic                                linkUp,
  output logic                                valid,
  output logic [MAX_LANES*OS_LEN*8-1:0]       outOs,
  output logic [1:0]                          osType,
  output logic                                skpSeen,
  output logic [MAX_LANES-1:0]                laneError
);

  localparam int CNT_W  = $clog2(OS_LEN + 1);
  localparam int OS_W   = OS_LEN * 8;
  localparam int BEAT_W = SYMS_PER_CLK * 8;

  localparam logic [0:0] ST_HUNT    = 1'b0;
  localparam logic [0:0] ST_COLLECT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS_LEN - 1);

  localparam logic [7:0] SYM_COM    = 8'hBC;
  localparam logic [7:0] SYM_SKP    = 8'h1C;
  localparam logic [7:0] SYM_TS1_G3 = 8'h1E;
  localparam logic [7:0] SYM_TS2_G3 = 8'h2D;
  localparam logic [7:0] SYM_SKP_G3 = 8'hAA;
  localparam logic [7:0] SYM_TS1_ID = 8'h4A;
  localparam logic [7:0] SYM_TS2_ID = 8'h45;

  localparam logic [MAX_LANES-1:0] LANE0_MASK = MAX_LANES'(1);

  logic [2:0]                 prev_gen_q, prev_gen_d;
  logic [4:0]                 prev_lanes_q, prev_lanes_d;
  logic                       high_gen;
  logic                       mode_change;
  logic                       beat;
  logic                       all_done;
  logic                       any_done;
  logic                       force_hunt;
  logic [MAX_LANES-1:0]       lane_active;
  logic [MAX_LANES-1:0]       lane_done;
  logic [MAX_LANES-1:0]       lane_skp;
  logic [MAX_LANES*OS_W-1:0]  comp_all;

  logic                       valid_q, valid_d;
  logic [MAX_LANES*OS_W-1:0]  out_os_q, out_os_d;
  logic [1:0]                 os_type_q, os_type_d;
  logic                       skp_seen_q, skp_seen_d;
  logic [MAX_LANES-1:0]       lane_error_q, lane_error_d;

  assign high_gen    = (gen >= 3'd3);
  assign mode_change = (gen != prev_gen_q) || (numberOfDetectedLanes != prev_lanes_q);
  assign beat        = validFromLMC && !linkUp && !mode_change;
  assign all_done    = (|lane_active) && (lane_done == lane_active);
  assign any_done    = |lane_done;
  // A partial completion discards every lane's progress, including sets just started.
  assign force_hunt  = linkUp || mode_change || (beat && any_done && !all_done);

  for (genvar gi = 0; gi < MAX_LANES; gi++) begin : g_lane
    logic                 st_q, st_d, st_scan;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_scan;
    logic [OS_W-1:0]      buf_q, buf_d, buf_scan;
    logic [OS_W-1:0]      comp_os;
    logic                 done_scan;
    logic                 skp_scan;

    assign lane_active[gi] = (32'(numberOfDetectedLanes) > gi);

    // Walk the beat symbol by symbol so a lane can finish one set and start the next.
    always_comb begin
      logic [7:0] sym;
      sym       = '0;
      st_scan   = st_q;
      cnt_scan  = cnt_q;
      buf_scan  = buf_q;
      comp_os   = '0;
      done_scan = 1'b0;
      skp_scan  = 1'b0;
      for (int s = 0; s < SYMS_PER_CLK; s++) begin
        sym = data[gi*BEAT_W + s*8 +: 8];
        if (st_scan == ST_HUNT) begin
          if (high_gen && sym == SYM_SKP_G3) begin
            skp_scan = 1'b1;
          end else if ((high_gen && (sym == SYM_TS1_G3 || sym == SYM_TS2_G3)) ||
                       (!high_gen && sym == SYM_COM)) begin
            buf_scan[7:0] = sym;
            cnt_scan      = CNT_ONE;
            st_scan       = ST_COLLECT;
          end
        end else if (!high_gen && cnt_scan == CNT_ONE && sym == SYM_SKP) begin
          st_scan  = ST_HUNT;
          cnt_scan = '0;
          skp_scan = 1'b1;
        end else begin
          buf_scan[int'(cnt_scan)*8 +: 8] = sym;
          if (cnt_scan == CNT_LAST) begin
            comp_os   = buf_scan;
            done_scan = 1'b1;
            st_scan   = ST_HUNT;
            cnt_scan  = '0;
          end else begin
            cnt_scan = cnt_scan + 1'b1;
          end
        end
      end
    end

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      buf_d = buf_q;
      if (force_hunt || !lane_active[gi]) begin
        st_d  = ST_HUNT;
        cnt_d = '0;
      end else if (beat) begin
        st_d  = st_scan;
        cnt_d = cnt_scan;
        buf_d = buf_scan;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        st_q  <= ST_HUNT;
        cnt_q <= '0;
        buf_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        buf_q <= buf_d;
      end
    end

    assign lane_done[gi]                = done_scan && lane_active[gi];
    assign lane_skp[gi]                 = skp_scan && lane_active[gi];
    assign comp_all[gi*OS_W +: OS_W]    = lane_active[gi] ? comp_os : '0;
  end

  always_comb begin
    logic       body_ts1;
    logic       body_ts2;
    logic [7:0] sym0;
    body_ts1 = 1'b1;
    body_ts2 = 1'b1;
    sym0     = comp_all[7:0];
    for (int k = 6; k < OS_LEN; k++) begin
      if (comp_all[k*8 +: 8] != SYM_TS1_ID) body_ts1 = 1'b0;
      if (comp_all[k*8 +: 8] != SYM_TS2_ID) body_ts2 = 1'b0;
    end

    prev_gen_d   = gen;
    prev_lanes_d = numberOfDetectedLanes;
    valid_d      = beat && all_done;
    lane_error_d = (beat && any_done && !all_done) ? lane_done : '0;
    skp_seen_d   = beat && ((lane_skp & LANE0_MASK) != '0);
    out_os_d     = out_os_q;
    os_type_d    = os_type_q;
    if (valid_d) begin
      out_os_d = comp_all;
      if (high_gen) begin
        os_type_d = (sym0 == SYM_TS1_G3) ? 2'd1 :
                    (sym0 == SYM_TS2_G3) ? 2'd2 : 2'd0;
      end else begin
        os_type_d = body_ts1 ? 2'd1 : (body_ts2 ? 2'd2 : 2'd0);
      end
    end
  end

  // Mode history loads the live inputs during reset so the first cycle after reset is not a mode change.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_gen_q   <= gen;
      prev_lanes_q <= numberOfDetectedLanes;
      valid_q      <= 1'b0;
      out_os_q     <= '0;
      os_type_q    <= 2'd0;
      skp_seen_q   <= 1'b0;
      lane_error_q <= '0;
    end else begin
      prev_gen_q   <= prev_gen_d;
      prev_lanes_q <= prev_lanes_d;
      valid_q      <= valid_d;
      out_os_q     <= out_os_d;
      os_type_q    <= os_type_d;
      skp_seen_q   <= skp_seen_d;
      lane_error_q <= lane_error_d;
    end
  end

  assign valid     = valid_q;
  assign outOs     = out_os_q;
  assign osType    = os_type_q;
  assign skpSeen   = skp_seen_q;
  assign laneError = lane_error_q;

endmodule
